// File: rtl/awmc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | awmc_pkg : shared AWMC encodings, panel state enum and defaults    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package awmc_pkg;

  localparam logic [2:0] STAGE_IDLE  = 3'b111;
  localparam logic [2:0] STAGE_FILL  = 3'd0;
  localparam logic [2:0] STAGE_WASH  = 3'd1;
  localparam logic [2:0] STAGE_RINSE = 3'd2;
  localparam logic [2:0] STAGE_SPIN  = 3'd3;
  localparam logic [2:0] STAGE_STOP  = 3'd4;

  typedef enum logic [2:0] {
    PS_IDLE     = 3'd0,
    PS_RUN      = 3'd1,
    PS_PAUSED   = 3'd2,
    PS_LID_HOLD = 3'd3,
    PS_DONE     = 3'd4
  } panel_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_BUZZ_CYCLES     = 200;

endpackage
`default_nettype wire

// File: rtl/awmc_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | awmc_debounce : 2-flop synchroniser, counter debounce, rising edge |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module awmc_debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync_meta;
  logic          sync_out;
  logic          level_q;
  logic [CW-1:0] cnt;

  // A full count flips the level on the following edge, whatever the sample then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= RESET_LEVEL;
      sync_out  <= RESET_LEVEL;
      level     <= RESET_LEVEL;
      level_q   <= RESET_LEVEL;
      cnt       <= '0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
      level_q   <= level;
      if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else if (sync_out != level) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule
`default_nettype wire

// File: rtl/awmc_panel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | awmc_panel : front-panel conditioner and session FSM for the AWMC  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module awmc_panel
  import awmc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int BUZZ_CYCLES     = DEFAULT_BUZZ_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_pause_raw,
  input  logic       lid_open_raw,
  input  logic       done,
  output logic       start,
  output logic       pause,
  output logic       buzzer,
  output logic [2:0] panel_state
);

  localparam int            BW        = $clog2(BUZZ_CYCLES + 1);
  localparam logic [BW-1:0] BUZZ_MAX  = BW'(BUZZ_CYCLES);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);

  logic start_level;
  logic start_press;
  logic pause_level;
  logic pause_press;
  logic lid_open;
  logic lid_rise_unused;

  panel_state_t  state;
  panel_state_t  next_state;
  logic [BW-1:0] buzz_cnt;
  logic          start_next;
  logic          pause_next;
  logic          buzzer_next;

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_start (
    .clk(clk), .reset(reset), .raw(btn_start_raw), .level(start_level), .rise(start_press)
  );

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_pause (
    .clk(clk), .reset(reset), .raw(btn_pause_raw), .level(pause_level), .rise(pause_press)
  );

  // Lid powers up as open so nothing starts until a closed lid has been debounced.
  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_lid (
    .clk(clk), .reset(reset), .raw(lid_open_raw), .level(lid_open), .rise(lid_rise_unused)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PS_IDLE;
      start    <= 1'b0;
      pause    <= 1'b0;
      buzzer   <= 1'b0;
      buzz_cnt <= '0;
    end else begin
      state  <= next_state;
      start  <= start_next;
      pause  <= pause_next;
      buzzer <= buzzer_next;
      if (next_state == PS_DONE && state != PS_DONE) begin
        buzz_cnt <= '0;
      end else if (state == PS_DONE && buzz_cnt != BUZZ_MAX) begin
        buzz_cnt <= buzz_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      PS_IDLE: begin
        if (start_press && !lid_open) next_state = PS_RUN;
      end
      PS_RUN: begin
        if (done)             next_state = PS_DONE;
        else if (lid_open)    next_state = PS_LID_HOLD;
        else if (pause_press) next_state = PS_PAUSED;
      end
      PS_PAUSED: begin
        if (lid_open)                        next_state = PS_LID_HOLD;
        else if (pause_press || start_press) next_state = PS_RUN;
      end
      PS_LID_HOLD: begin
        if (start_press && !lid_open) next_state = PS_RUN;
      end
      PS_DONE: begin
        // buzz_cnt counts completed buzzer cycles; this edge completes the last one
        if (start_press || buzz_cnt == BUZZ_LAST) next_state = PS_IDLE;
      end
      default: next_state = PS_IDLE;
    endcase
  end

  always_comb begin
    start_next  = (next_state == PS_RUN) && (state != PS_RUN);
    pause_next  = (next_state == PS_PAUSED) || (next_state == PS_LID_HOLD);
    buzzer_next = (next_state == PS_DONE);
  end

  assign panel_state = state;

endmodule
`default_nettype wire

// File: doc/awmc_panel.md
# awmc_panel

Front-panel input conditioner for the automatic washing machine controller (AWMC), sitting directly upstream of it. It synchronises and debounces the raw start, pause and lid-open switches and runs a small session FSM. It drives the AWMC `start` and `pause` inputs, and sounds a buzzer when the AWMC reports `done`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive disagreeing samples needed to flip a debounced level. Must be ≥ 2.
- `BUZZ_CYCLES`, default 200: buzzer on-time after completion. Must be ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high; clock `clk`.
- `btn_start_raw`  in  1  raw start push-button, active-high, asynchronous, bouncy.
- `btn_pause_raw`  in  1  raw pause push-button, active-high, asynchronous, bouncy.
- `lid_open_raw`  in  1  raw lid switch, 1 = open, asynchronous, bouncy.
- `done`  in  1  AWMC completion flag, level, synchronous to `clk`.
- `start`  out  1  single-cycle start/resume pulse to AWMC.
- `pause`  out  1  level pause request to AWMC.
- `buzzer`  out  1  buzzer drive.
- `panel_state`  out  3  current FSM state, for LEDs.

## Operation
- **Input path (per raw input):** 2-flop synchroniser, then debounce.
  - The debounce counter increments while the synchronised value ≠ the debounced level, and clears to 0 when they agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - Reset values: debounced levels = 0, except the lid, which is 1 (treated as open until proven closed).
- **Press events:** `start_press` and `pause_press` are the rising edges of the debounced button levels, one cycle each. `lid_open` is the debounced lid level.
- **FSM states** (`panel_state` encoding): IDLE=0, RUN=1, PAUSED=2, LID_HOLD=3, DONE=4. Reset state is IDLE.
- **IDLE:** `pause`=0.
  - `start_press` with `!lid_open`: pulse `start`, go to RUN.
  - `start_press` with the lid open is ignored.
  - `done` is ignored.
- **RUN:** `pause`=0. Priority, highest first:
  - `done` → DONE.
  - `lid_open` → LID_HOLD.
  - `pause_press` → PAUSED.
  - `start_press` is ignored.
- **PAUSED:** `pause`=1.
  - `lid_open` → LID_HOLD.
  - Otherwise, `pause_press` or `start_press` → RUN, with a `start` pulse.
- **LID_HOLD:** `pause`=1. Leaves only on `start_press` with `!lid_open` → RUN, with a `start` pulse. Closing the lid alone never resumes.
- **DONE:** `pause`=0, `buzzer`=1, buzz counter runs.
  - When the counter reaches `BUZZ_CYCLES` → IDLE, with `buzzer`=0.
  - `start_press` silences early → IDLE, with no `start` pulse.
- **Simultaneous events:**
  - `start_press` and `pause_press` in the same cycle: pause wins in RUN; either causes resume in PAUSED.
  - `done` beats everything in RUN.
- **Counters:**
  - Debounce counter width: `$clog2(DEBOUNCE_CYCLES+1)`.
  - Buzz counter width: `$clog2(BUZZ_CYCLES+1)`.
  - Both saturate, never wrap. The buzz counter clears on entry to DONE.
- **Outputs:** all registered.
  - `start` is high for exactly one cycle per accepted event.
  - `pause` and `buzzer` are decoded from the registered state.

## Timing
- Reset (asynchronous, any time, including mid-session): state=IDLE, `start`=0, `pause`=0, `buzzer`=0, `panel_state`=0, all counters 0. Synchroniser flops reset to 0, except the lid path, which resets to 1.
- Raw button latency: for a clean raw rising edge first sampled at edge k, `start` (or the FSM transition) takes effect at edge k + `DEBOUNCE_CYCLES` + 3.
  - 2 cycles synchroniser.
  - `DEBOUNCE_CYCLES` cycles debounce.
  - 1 cycle registered output.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles produce no event.
- `done` to `buzzer`: one cycle, i.e. `done` high at edge k in RUN gives `buzzer`=1 after edge k+1.
- Buzzer on-time: exactly `BUZZ_CYCLES` cycles unless silenced early.
- A held button yields one event only. Re-arming requires a debounced release.

## Structure
- Shared package `awmc_pkg`:
  - AWMC stage encodings (IDLE=3'b111, FILL=0, WASH=1, RINSE=2, SPIN=3, STOP=4).
  - `panel_state_t` enum.
  - Default `DEBOUNCE_CYCLES` and `BUZZ_CYCLES`.
- Sub-module `awmc_debounce` (synchroniser + debounce + rising-edge output, parameterised by reset level), instantiated three times. FSM and buzz counter live in `awmc_panel`.

## Test plan
Run with `DEBOUNCE_CYCLES`=4 and `BUZZ_CYCLES`=8.
- **Start latency:** lid closed and settled, `btn_start_raw` rises at edge 10 → `start` high for exactly edge 17, `panel_state`=1.
- **Bounce rejection:** `btn_pause_raw` toggles every 2 cycles for 20 cycles, then holds high → exactly one PAUSED entry (`pause`=1). Releasing, then pressing again → RUN plus a one-cycle `start` pulse.
- **Lid interlock:** in RUN, lid opens → LID_HOLD with `pause`=1. Lid closes with no button press → stays in LID_HOLD. `start_press` with the lid open → no change. After a debounced close, `start_press` → RUN plus a `start` pulse.
- **Completion:** in RUN, drive `done`=1 → `buzzer` high for exactly 8 cycles, then IDLE. Repeat with a `start_press` at buzz cycle 3 → `buzzer` drops, IDLE, no `start` pulse.
- **Simultaneous events and reset:**
  - `done` and `pause_press` in the same RUN cycle → DONE.
  - `start_press` and `pause_press` in the same RUN cycle → PAUSED.
  - Assert `reset` mid-buzz → all outputs 0 asynchronously, IDLE, and the lid is considered open until `DEBOUNCE_CYCLES`+2 closed samples.
